// File: rtl/gf_word_loader_pkg.sv
// Shared constants, state encoding and word-slicing helper for the GF(2^163) word loader.
package gf_word_loader_pkg;

  localparam int unsigned FieldW   = 163;
  localparam int unsigned WordW    = 32;
  localparam int unsigned NumWords = 6;
  // Bits of the field element that land in the last (partial) word.
  localparam int unsigned TopBits  = FieldW - (NumWords - 1) * WordW;

  typedef logic [2:0] widx_t;

  localparam widx_t LastWord = 3'd5;
  localparam widx_t FullCnt  = 3'd6;

  typedef enum logic [1:0] {
    StLoad   = 2'd0,
    StRun    = 2'd1,
    StUnload = 2'd2
  } state_e;

  // Word idx of a field element, last word zero-extended above its valid bits.
  function automatic logic [WordW-1:0] field_word(input logic [FieldW-1:0] v, input widx_t idx);
    logic [WordW-1:0] w;
    w = '0;
    case (idx)
      3'd0:    w = v[31:0];
      3'd1:    w = v[63:32];
      3'd2:    w = v[95:64];
      3'd3:    w = v[127:96];
      3'd4:    w = v[159:128];
      3'd5:    w[TopBits-1:0] = v[FieldW-1 -: TopBits];
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/gf_word_pack.sv
// Six-word operand register with indexed write; word 5 keeps only its low field bits.
module gf_word_pack
  import gf_word_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  widx_t             idx,
  input  logic [WordW-1:0]  data,
  output logic [FieldW-1:0] operand
);

  logic [WordW-1:0]   low_q [NumWords-1];
  logic [TopBits-1:0] top_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(NumWords) - 1; k++) low_q[k] <= '0;
      top_q <= '0;
    end else if (we) begin
      if (idx == LastWord) begin
        top_q <= data[TopBits-1:0];
      end else begin
        for (int k = 0; k < int'(NumWords) - 1; k++) begin
          if (idx == widx_t'(k)) low_q[k] <= data;
        end
      end
    end
  end

  always_comb begin
    operand = '0;
    for (int k = 0; k < int'(NumWords) - 1; k++) operand[k*WordW +: WordW] = low_q[k];
    operand[FieldW-1 -: TopBits] = top_q;
  end

endmodule

// File: rtl/gf_word_loader.sv
// Word-serial operand loader / result unloader around a GF(2^163) multiplier.
// Optional sticky protocol-error flag `err` when GF_WORD_LOADER_ERR_EN is defined.
module gf_word_loader
  import gf_word_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [WordW-1:0]  wr_data,
  output logic [FieldW-1:0] mult_a,
  output logic [FieldW-1:0] mult_b,
  output logic              mult_start,
  input  logic [FieldW-1:0] mult_z,
  input  logic              mult_done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WordW-1:0]  rd_data,
  output logic              busy
`ifdef GF_WORD_LOADER_ERR_EN
  ,
  output logic              err
`endif
);

  state_e            state;
  widx_t             cnt_a, cnt_b, rd_idx;
  widx_t             cnt_a_nxt, cnt_b_nxt;
  logic [FieldW-1:0] result;
  logic              wr_a, wr_b;

  // clr suppresses writes so it wins over a same-cycle load.
  always_comb begin
    wr_a      = (state == StLoad) && wr_en && !wr_sel && (cnt_a != FullCnt) && !clr;
    wr_b      = (state == StLoad) && wr_en &&  wr_sel && (cnt_b != FullCnt) && !clr;
    cnt_a_nxt = wr_a ? cnt_a + 3'd1 : cnt_a;
    cnt_b_nxt = wr_b ? cnt_b + 3'd1 : cnt_b;
  end

  gf_word_pack u_pack_a (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_a),
    .idx     (cnt_a),
    .data    (wr_data),
    .operand (mult_a)
  );

  gf_word_pack u_pack_b (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_b),
    .idx     (cnt_b),
    .data    (wr_data),
    .operand (mult_b)
  );

  assign rd_data = rd_valid ? field_word(result, rd_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StLoad;
      cnt_a      <= '0;
      cnt_b      <= '0;
      rd_idx     <= '0;
      result     <= '0;
      mult_start <= 1'b0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
    end else if (clr) begin
      state      <= StLoad;
      cnt_a      <= '0;
      cnt_b      <= '0;
      rd_idx     <= '0;
      mult_start <= 1'b0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        StLoad: begin
          cnt_a <= cnt_a_nxt;
          cnt_b <= cnt_b_nxt;
          if (cnt_a_nxt == FullCnt && cnt_b_nxt == FullCnt) begin
            state      <= StRun;
            mult_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StRun: begin
          if (mult_done) begin
            result     <= mult_z;
            state      <= StUnload;
            mult_start <= 1'b0;
            rd_valid   <= 1'b1;
            rd_idx     <= '0;
          end
        end
        StUnload: begin
          if (rd_valid && rd_ready) begin
            if (rd_idx == LastWord) begin
              state    <= StLoad;
              rd_valid <= 1'b0;
              busy     <= 1'b0;
              rd_idx   <= '0;
              cnt_a    <= '0;
              cnt_b    <= '0;
            end else begin
              rd_idx <= rd_idx + 3'd1;
            end
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

`ifdef GF_WORD_LOADER_ERR_EN
  logic wr_err;

  assign wr_err = wr_en && ((state != StLoad) || (wr_sel ? (cnt_b == FullCnt) : (cnt_a == FullCnt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (wr_err) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gf_word_loader.sv
// Directed, table-driven bench for gf_word_loader; the bench plays the multiplier.
module tb_gf_word_loader;

  logic         clk = 1'b0;
  logic         rst, clr, wr_en, wr_sel, mult_done, rd_ready;
  logic [31:0]  wr_data;
  logic [162:0] mult_a, mult_b, mult_z;
  logic         mult_start, rd_valid, busy;
  logic [31:0]  rd_data;
`ifdef GF_WORD_LOADER_ERR_EN
  logic         err;
`endif

  gf_word_loader dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_start (mult_start),
    .mult_z     (mult_z),
    .mult_done  (mult_done),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .busy       (busy)
`ifdef GF_WORD_LOADER_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][31:0] a;
    logic [5:0][31:0] b;
    logic [5:0][31:0] z;
  } vec_t;

  localparam int NumVec = 7;
  vec_t vecs [NumVec];
  int   total = 0;
  int   bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk163(input string name, input logic [162:0] act, input logic [162:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [162:0] pack(input logic [5:0][31:0] w);
    return {w[5][2:0], w[4], w[3], w[2], w[1], w[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic sel, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    wr_data = '0;
  endtask

  // Interleaved A/B load; start must appear right after the final B word.
  task automatic load(input logic [5:0][31:0] a, input logic [5:0][31:0] b);
    for (int k = 0; k < 6; k++) begin
      write(1'b0, a[k]);
      if (k == 5) begin
        chk1("start_before_last", mult_start, 1'b0);
        chk1("busy_before_last", busy, 1'b0);
      end
      write(1'b1, b[k]);
    end
    chk1("start_on_entry", mult_start, 1'b1);
    chk1("busy_run", busy, 1'b1);
    chk163("mult_a", mult_a, pack(a));
    chk163("mult_b", mult_b, pack(b));
  endtask

  task automatic run_mult(input logic [162:0] z);
    mult_z    = z;
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    mult_z    = '0;
    chk1("start_after_done", mult_start, 1'b0);
    chk1("valid_after_done", rd_valid, 1'b1);
    chk1("busy_unload", busy, 1'b1);
  endtask

  task automatic unload(input logic [5:0][31:0] z, input int stall);
    for (int w = 0; w < 6; w++) begin
      chk1("rd_valid", rd_valid, 1'b1);
      chk32("rd_data", rd_data, z[w]);
      if (w == stall) begin
        rd_ready = 1'b0;
        repeat (3) begin
          tick();
          chk1("rd_valid_hold", rd_valid, 1'b1);
          chk32("rd_data_hold", rd_data, z[w]);
        end
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    chk1("busy_after_unload", busy, 1'b0);
    chk1("valid_after_unload", rd_valid, 1'b0);
    chk32("rd_data_idle", rd_data, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // Hand-computed products mod x^163 + x^7 + x^6 + x^3 + 1.
    for (int i = 0; i < NumVec; i++) vecs[i] = '0;
    vecs[0].a[0] = 32'h1;        vecs[0].b[0] = 32'h1; vecs[0].z[0] = 32'h1;
    vecs[1].a[5] = 32'h4;        vecs[1].b[0] = 32'h2; vecs[1].z[0] = 32'hC9;
    vecs[2].a[5] = 32'hFFFFFFFC; vecs[2].b[0] = 32'h2; vecs[2].z[0] = 32'hC9;
    vecs[3].a[0] = 32'h3;        vecs[3].b[0] = 32'h3; vecs[3].z[0] = 32'h5;
    vecs[4].a[1] = 32'h1;        vecs[4].b[1] = 32'h1; vecs[4].z[2] = 32'h1;
    vecs[5].a[5] = 32'h4;        vecs[5].b[0] = 32'h4; vecs[5].z[0] = 32'h192;
    vecs[6].a[5] = 32'h4;        vecs[6].b[0] = 32'h1; vecs[6].z[5] = 32'h4;

    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0;
    mult_z = '0; mult_done = 1'b0; rd_ready = 1'b0;
    tick();
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_start", mult_start, 1'b0);
    chk1("rst_valid", rd_valid, 1'b0);
    chk32("rst_rd_data", rd_data, 32'h0);
    chk163("rst_mult_a", mult_a, '0);
    chk163("rst_mult_b", mult_b, '0);
    rst = 1'b1;
    tick();

    // Stray product pulse while loading must not start an unload.
    mult_z    = '1;
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    chk1("load_done_ignored_valid", rd_valid, 1'b0);
    chk1("load_done_ignored_busy", busy, 1'b0);

    for (int i = 0; i < NumVec; i++) begin
      load(vecs[i].a, vecs[i].b);
      repeat (3) tick();
      chk1("start_held", mult_start, 1'b1);
      run_mult(pack(vecs[i].z));
      unload(vecs[i].z, (i == 4) ? 2 : -1);
      chk163("a_retained", mult_a, pack(vecs[i].a));
    end

    // Extra A write, then a write while running: both dropped.
    v = '0;
    v.a[0] = 32'h5; v.b[0] = 32'h5; v.z[0] = 32'h11;
    write(1'b0, v.a[0]);
    write(1'b1, v.b[0]);
    for (int k = 1; k < 6; k++) write(1'b0, v.a[k]);
    write(1'b0, 32'hDEADBEEF);
    chk163("seventh_a_ignored", mult_a, pack(v.a));
    for (int k = 1; k < 5; k++) write(1'b1, v.b[k]);
    chk1("start_b_incomplete", mult_start, 1'b0);
    write(1'b1, v.b[5]);
    chk1("start_after_b6", mult_start, 1'b1);
    write(1'b0, 32'hFFFFFFFF);
    chk163("run_write_ignored", mult_a, pack(v.a));
    chk1("run_write_start", mult_start, 1'b1);
`ifdef GF_WORD_LOADER_ERR_EN
    chk1("err_set", err, 1'b1);
`endif
    run_mult(pack(v.z));
    unload(v.z, -1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
`ifdef GF_WORD_LOADER_ERR_EN
    chk1("err_cleared", err, 1'b0);
`endif

    // Soft clear mid-run, with a simultaneous product pulse.
    load(vecs[0].a, vecs[0].b);
    tick();
    clr       = 1'b1;
    mult_done = 1'b1;
    mult_z    = '1;
    tick();
    clr       = 1'b0;
    mult_done = 1'b0;
    chk1("clr_start", mult_start, 1'b0);
    chk1("clr_busy", busy, 1'b0);
    chk1("clr_valid", rd_valid, 1'b0);
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    mult_z    = '0;
    chk1("clr_late_done_valid", rd_valid, 1'b0);
    chk1("clr_late_done_busy", busy, 1'b0);
    load(vecs[3].a, vecs[3].b);
    run_mult(pack(vecs[3].z));
    unload(vecs[3].z, -1);

    // Asynchronous reset mid-run abandons the operation.
    load(vecs[0].a, vecs[0].b);
    tick();
    rst = 1'b0;
    #1;
    chk1("rst_run_start", mult_start, 1'b0);
    chk1("rst_run_busy", busy, 1'b0);
    chk163("rst_run_mult_a", mult_a, '0);
    tick();
    rst = 1'b1;
    tick();
    mult_z    = '1;
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    mult_z    = '0;
    chk1("rst_late_done_valid", rd_valid, 1'b0);
    chk1("rst_late_done_start", mult_start, 1'b0);
    load(vecs[5].a, vecs[5].b);
    run_mult(pack(vecs[5].z));
    unload(vecs[5].z, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf_word_loader.md
GF_WORD_LOADER -- requirements
Module: gf_word_loader

Interface
REQ-001 SHALL have port `clk` (input, 1): single rising-edge clock for all state.
REQ-002 SHALL have port `rst` (input, 1): asynchronous, active-low reset. This polarity and synchronicity are fixed.
REQ-003 SHALL have port `clr` (input, 1): synchronous soft clear, active-high.
REQ-004 SHALL have port `wr_en` (input, 1): write strobe for one 32-bit operand word.
REQ-005 SHALL have port `wr_sel` (input, 1): operand select, 0 = operand A, 1 = operand B.
REQ-006 SHALL have port `wr_data` (input, 32): operand word, least-significant word first.
REQ-007 SHALL have port `mult_a` / `mult_b` (output, 163 each): operands to the GF(2^163) multiplier.
REQ-008 SHALL have port `mult_start` (output, 1): multiplier start, held level-high.
REQ-009 SHALL have port `mult_z` (input, 163): multiplier product.
REQ-010 SHALL have port `mult_done` (input, 1): one-cycle product-valid pulse.
REQ-011 SHALL have port `rd_valid` (output, 1): a result word is available.
REQ-012 SHALL have port `rd_ready` (input, 1): consumer accepts the result word.
REQ-013 SHALL have port `rd_data` (output, 32): result word, least-significant word first.
REQ-014 SHALL have port `busy` (output, 1): high in every state except LOAD.

Function
REQ-015 SHALL implement states LOAD, RUN, UNLOAD.
- LOAD -> RUN when both word counters equal 6.
- RUN -> UNLOAD on the cycle `mult_done`=1.
- UNLOAD -> LOAD on acceptance of word 5.
REQ-016 SHALL, in LOAD, write `wr_data` into word slot cnt_A or cnt_B (chosen by `wr_sel`) when `wr_en`=1, then increment that counter.
REQ-017 SHALL saturate each counter at 6 and ignore writes to a full operand.
REQ-018 SHALL map word k to operand bits [32k+31:32k] for k=0..4; word 5 bits [2:0] SHALL map to bits [162:160] and bits [31:3] SHALL be discarded.
REQ-019 SHALL ignore `wr_en` in RUN and UNLOAD.
REQ-020 SHALL drive `mult_a`/`mult_b` from the operand registers, unchanged throughout RUN.
REQ-021 SHALL assert `mult_start` registered on entry to RUN, hold it through RUN, and deassert it the cycle after `mult_done`.
REQ-022 SHALL capture `mult_z` into the result register on the `mult_done` cycle.
REQ-023 SHALL, in UNLOAD, present `rd_valid`=1 and `rd_data` = result word rd_idx, with rd_idx starting at 0.
REQ-024 SHALL advance rd_idx on `rd_valid`&&`rd_ready`, and hold `rd_data` stable while `rd_ready`=0.
REQ-025 SHALL zero bits [31:3] of result word 5.
REQ-026 SHALL clear both counters and rd_idx on UNLOAD -> LOAD; operand registers are retained.
REQ-027 SHALL, when `clr`=1, return to LOAD, zero counters, rd_idx and `mult_start`, and deassert `rd_valid` next cycle.
REQ-028 SHALL give `clr` priority over every other event in the same cycle.
REQ-029 SHALL ignore `mult_done` outside RUN.
REQ-030 SHALL, when `wr_en` completes the 6th word of the second operand, enter RUN on the next cycle with `mult_start`=1.

Reset
REQ-031 SHALL, while `rst`=0, force state LOAD, zero counters, rd_idx, operand and result registers, and drive `mult_start`=0, `rd_valid`=0, `busy`=0, `rd_data`=0.
REQ-032 SHALL treat reset during RUN as an abandoned operation; the pending `mult_done` is ignored after release.

Configuration
REQ-033 SHALL, with GF_WORD_LOADER_ERR_EN defined, add output `err` (1 bit, sticky).
- `err` is set by `wr_en` in RUN/UNLOAD or by a write to a full operand.
- `err` is cleared by `clr` or `rst`.
REQ-034 SHALL, without GF_WORD_LOADER_ERR_EN, omit the `err` port and its logic; all other behaviour is identical.

Structure
REQ-035 SHALL place in the shared GF package:
- field width 163
- word width 32
- words per operand 6
- the state encoding constants
REQ-036 SHALL include one sub-module `gf_word_pack`: a 6-word by 32-bit operand register with indexed write.
REQ-037 SHALL instantiate `gf_word_pack` twice, once for A and once for B.

Verification
REQ-038 SHALL cover: A words {1,0,0,0,0,0}, B words {1,0,0,0,0,0} -> `mult_start` held until `mult_done`; result words {1,0,0,0,0,0}.
REQ-039 SHALL cover: A = x^162 (word5=0x00000004), B = x (word0=0x00000002) -> result word0=0x000000C9, words 1-5 = 0.
REQ-040 SHALL cover: interleaved A/B writes plus a 7th A write and a write during RUN -> ignored; `err`=1 with GF_WORD_LOADER_ERR_EN defined.
REQ-041 SHALL cover: `rd_ready` low for 3 cycles on word 2 -> `rd_data` stable; exactly 6 accepted transfers, then `busy`=0.
REQ-042 SHALL cover: `clr` or `rst` asserted mid-RUN -> `mult_start`=0 next cycle, a later `mult_done` ignored, and a new load sequence produces the correct product.
